// File: rtl/fir_pkg.sv
// Shared types and Q1.15 rescale helpers for the FIR output path.
package fir_pkg;

   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned ACC_W    = 32;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic signed [ACC_W-1:0]    acc_t;

   localparam sample_t Q15_MAX = 16'sh7FFF;
   localparam sample_t Q15_MIN = 16'sh8000;

   // Round-half-up shift done in 33 bits so the bias add cannot wrap.
   function automatic logic signed [ACC_W:0] round_shift(acc_t acc, int shift);
      logic signed [ACC_W:0] ext;
      logic signed [ACC_W:0] bias;
      ext  = 33'(acc);
      bias = 33'sd1 <<< (shift - 1);
      return (ext + bias) >>> shift;
   endfunction

   function automatic logic q15_sat(acc_t acc, int shift);
      logic signed [ACC_W:0] r;
      r = round_shift(acc, shift);
      return (r > 33'sd32767) || (r < -33'sd32768);
   endfunction

   function automatic sample_t sat_round_q15(acc_t acc, int shift);
      logic signed [ACC_W:0] r;
      r = round_shift(acc, shift);
      if (r > 33'sd32767)
         return Q15_MAX;
      else if (r < -33'sd32768)
         return Q15_MIN;
      else
         return sample_t'(r[SAMPLE_W-1:0]);
   endfunction

endpackage

// File: rtl/fir_out_stage_if.sv
// Filter result input stream and valid/ready Q1.15 output stream.
interface fir_out_stage_if;
   import fir_pkg::*;

   acc_t    y_in;
   logic    y_in_valid;
   sample_t dout;
   logic    dout_valid;
   logic    dout_ready;

   modport master (
      output y_in, y_in_valid, dout_ready,
      input  dout, dout_valid
   );

   modport slave (
      input  y_in, y_in_valid, dout_ready,
      output dout, dout_valid
   );

endinterface

// File: rtl/fir_out_fifo.sv
// Show-ahead circular FIFO with occupancy count and sticky overflow on dropped pushes.
module fir_out_fifo #(
   parameter  int unsigned FIFO_DEPTH = 8,
   parameter  int unsigned DATA_W     = 16,
   localparam int unsigned AW         = $clog2(FIFO_DEPTH),
   localparam int unsigned LW         = AW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop_ready,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic [LW-1:0]     level,
   output logic              overflow
);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              full_c;
   logic              pop_c;
   logic              accept_c;
   logic [LW-1:0]     level_next_c;

   // A push into a full FIFO is still taken when the head leaves in the same cycle.
   always_comb begin
      full_c       = (level == LW'(FIFO_DEPTH));
      pop_c        = valid && pop_ready;
      accept_c     = push && (!full_c || pop_c);
      level_next_c = level;
      case ({accept_c, pop_c})
         2'b10:   level_next_c = level + LW'(1);
         2'b01:   level_next_c = level - LW'(1);
         default: level_next_c = level;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         valid    <= 1'b0;
         overflow <= 1'b0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++)
            mem[i] <= '0;
      end else begin
         if (accept_c) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_c)
            rd_ptr <= rd_ptr + AW'(1);
         level <= level_next_c;
         valid <= (level_next_c != '0);
         if (push && !accept_c)
            overflow <= 1'b1;
      end
   end

   assign data = mem[rd_ptr];

endmodule

// File: rtl/fir_out_stage.sv
// FIR output stage: Q1.15 rescale with rounding/saturation, decimation and output FIFO.
// Optional saturation counter port sat_count is built with FIR_OUT_SATCNT_EN.
module fir_out_stage
   import fir_pkg::*;
#(
   parameter int unsigned DECIM      = 1,
   parameter int unsigned SHIFT      = 7,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   fir_out_stage_if.slave              bus,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        overflow
`ifdef FIR_OUT_SATCNT_EN
   ,
   output logic [15:0]                 sat_count
`endif
);

   localparam int unsigned PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

   logic [PH_W-1:0] phase;
   logic            keep_c;
   sample_t         s1_data;
   logic            s1_keep;

   assign keep_c = bus.y_in_valid && (phase == '0);

   // Phase only moves on valid samples so gaps do not disturb the decimation pattern.
   always_ff @(posedge clk) begin
      if (rst)
         phase <= '0;
      else if (bus.y_in_valid)
         phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + PH_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_data <= '0;
         s1_keep <= 1'b0;
      end else begin
         s1_data <= sat_round_q15(bus.y_in, int'(SHIFT));
         s1_keep <= keep_c;
      end
   end

`ifdef FIR_OUT_SATCNT_EN
   logic s1_sat;

   always_ff @(posedge clk) begin
      if (rst)
         s1_sat <= 1'b0;
      else
         s1_sat <= q15_sat(bus.y_in, int'(SHIFT));
   end

   // Counts kept saturated samples, holding at the top value.
   always_ff @(posedge clk) begin
      if (rst)
         sat_count <= '0;
      else if (s1_keep && s1_sat && (sat_count != 16'hFFFF))
         sat_count <= sat_count + 16'd1;
   end
`endif

   fir_out_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .DATA_W     (SAMPLE_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (s1_keep),
      .push_data  (s1_data),
      .pop_ready  (bus.dout_ready),
      .data       (bus.dout),
      .valid      (bus.dout_valid),
      .level      (fifo_level),
      .overflow   (overflow)
   );

endmodule

// File: tb/tb_fir_out_stage.sv
// Scoreboard bench for fir_out_stage: one DECIM=1 instance and one DECIM=3 instance.
module tb_fir_out_stage;
   import fir_pkg::*;

   localparam int unsigned SHIFT = 7;
   localparam int unsigned DEPTH = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a;
   logic       rst_b;
   logic [3:0] lvl_a;
   logic [3:0] lvl_b;
   logic       ovf_a;
   logic       ovf_b;
`ifdef FIR_OUT_SATCNT_EN
   logic [15:0] sc_a;
   logic [15:0] sc_b;
`endif

   fir_out_stage_if ia ();
   fir_out_stage_if ib ();

   fir_out_stage #(.DECIM(1), .SHIFT(SHIFT), .FIFO_DEPTH(DEPTH)) u_a (
      .clk        (clk),
      .rst        (rst_a),
      .bus        (ia.slave),
      .fifo_level (lvl_a),
      .overflow   (ovf_a)
`ifdef FIR_OUT_SATCNT_EN
      ,
      .sat_count  (sc_a)
`endif
   );

   fir_out_stage #(.DECIM(3), .SHIFT(SHIFT), .FIFO_DEPTH(DEPTH)) u_b (
      .clk        (clk),
      .rst        (rst_b),
      .bus        (ib.slave),
      .fifo_level (lvl_b),
      .overflow   (ovf_b)
`ifdef FIR_OUT_SATCNT_EN
      ,
      .sat_count  (sc_b)
`endif
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] q_a[$];
   logic [15:0] q_b[$];
   logic [3:0]  max_b = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] model(input int y);
      longint r;
      r = (longint'(y) + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
      if (r > 32767)
         return 16'h7FFF;
      if (r < -32768)
         return 16'h8000;
      return 16'(r);
   endfunction

   // Output monitors: every accepted beat is checked against the scoreboard head.
   always @(negedge clk) begin
      if (!rst_a && ia.dout_valid && ia.dout_ready) begin
         if (q_a.size() == 0)
            check("a_extra_out", 32'(q_a.size()), 32'd1);
         else
            check("a_dout", {16'h0, ia.dout}, {16'h0, q_a.pop_front()});
      end
   end

   always @(negedge clk) begin
      if (!rst_b && ib.dout_valid && ib.dout_ready) begin
         if (q_b.size() == 0)
            check("b_extra_out", 32'(q_b.size()), 32'd1);
         else
            check("b_dout", {16'h0, ib.dout}, {16'h0, q_b.pop_front()});
      end
      if (!rst_b && lvl_b > max_b)
         max_b = lvl_b;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input int y, input bit keep);
      ia.y_in       = y;
      ia.y_in_valid = 1'b1;
      if (keep)
         q_a.push_back(model(y));
      tick();
      ia.y_in_valid = 1'b0;
   endtask

   task automatic send_b(input int y, input bit keep);
      ib.y_in       = y;
      ib.y_in_valid = 1'b1;
      if (keep)
         q_b.push_back(model(y));
      tick();
      ib.y_in_valid = 1'b0;
   endtask

   task automatic reset_a();
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      q_a.delete();
   endtask

   task automatic reset_b();
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      q_b.delete();
   endtask

   task automatic drain_a(input string tag);
      for (int i = 0; i < 60 && q_a.size() != 0; i++)
         tick();
      check(tag, 32'(q_a.size()), 32'd0);
   endtask

   task automatic drain_b(input string tag);
      for (int i = 0; i < 60 && q_b.size() != 0; i++)
         tick();
      check(tag, 32'(q_b.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ia.y_in = '0; ia.y_in_valid = 1'b0; ia.dout_ready = 1'b0;
      ib.y_in = '0; ib.y_in_valid = 1'b0; ib.dout_ready = 1'b0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      tick();
      tick();
      rst_a = 1'b0;
      rst_b = 1'b0;

      check("rst_dout", {16'h0, ia.dout}, 32'h0);
      check("rst_valid", 32'(ia.dout_valid), 32'd0);
      check("rst_level", 32'(lvl_a), 32'd0);
      check("rst_overflow", 32'(ovf_a), 32'd0);
`ifdef FIR_OUT_SATCNT_EN
      check("rst_sat_count", 32'(sc_a), 32'd0);
`endif

      // Rounding, two-cycle latency, then saturation
      ia.dout_ready = 1'b1;
      send_a(64, 1'b1);
      check("lat_cycle1_valid", 32'(ia.dout_valid), 32'd0);
      tick();
      check("lat_cycle2_valid", 32'(ia.dout_valid), 32'd1);
      check("lat_cycle2_dout", {16'h0, ia.dout}, 32'h1);
      send_a(63, 1'b1);
      send_a(-64, 1'b1);
      send_a(-65, 1'b1);
      send_a(int'(32'h7FFF_FFFF), 1'b1);
      send_a(int'(32'h8000_0000), 1'b1);
      repeat (3) tick();
`ifdef FIR_OUT_SATCNT_EN
      check("sat_count", 32'(sc_a), 32'd2);
`endif
      drain_a("round_drain");

      // Overflow: nine kept samples into an eight-deep FIFO with no consumer
      reset_a();
      ia.dout_ready = 1'b0;
      for (int i = 0; i < 9; i++)
         send_a((i + 1) <<< 7, i < 8);
      tick();
      tick();
      check("ovf_level", 32'(lvl_a), 32'd8);
      check("ovf_flag", 32'(ovf_a), 32'd1);
      check("ovf_head", {16'h0, ia.dout}, 32'h1);
      ia.dout_ready = 1'b1;
      drain_a("ovf_drain");
      check("ovf_sticky", 32'(ovf_a), 32'd1);
      check("ovf_empty_level", 32'(lvl_a), 32'd0);

      // Full FIFO with a push and a pop on the same edge
      reset_a();
      check("full_rst_overflow", 32'(ovf_a), 32'd0);
      ia.dout_ready = 1'b0;
      for (int i = 0; i < 8; i++)
         send_a((i + 10) <<< 7, 1'b1);
      tick();
      tick();
      check("full_level", 32'(lvl_a), 32'd8);
      send_a(99 <<< 7, 1'b1);
      ia.dout_ready = 1'b1;
      tick();
      ia.dout_ready = 1'b0;
      check("full_pp_level", 32'(lvl_a), 32'd8);
      check("full_pp_overflow", 32'(ovf_a), 32'd0);
      check("full_pp_head", {16'h0, ia.dout}, 32'd11);
      ia.dout_ready = 1'b1;
      drain_a("full_pp_drain");
      check("full_pp_overflow_end", 32'(ovf_a), 32'd0);

      // Decimation by 3 with gaps between valid samples
      ib.dout_ready = 1'b1;
      max_b = '0;
      for (int i = 1; i <= 7; i++) begin
         send_b(i * 128, ((i - 1) % 3) == 0);
         tick();
      end
      drain_b("decim_drain");
      check("decim_max_level", {28'h0, max_b}, 32'd1);

      // Mid-stream reset with the phase left non-zero
      reset_b();
      ib.dout_ready = 1'b0;
      for (int i = 0; i < 13; i++)
         send_b((i + 20) <<< 7, (i % 3) == 0);
      tick();
      tick();
      check("mid_level_before", 32'(lvl_b), 32'd5);
      reset_b();
      check("mid_valid", 32'(ib.dout_valid), 32'd0);
      check("mid_level", 32'(lvl_b), 32'd0);
      check("mid_overflow", 32'(ovf_b), 32'd0);
      check("mid_dout", {16'h0, ib.dout}, 32'h0);
      ib.dout_ready = 1'b1;
      send_b(5 <<< 7, 1'b1);
      tick();
      check("mid_first_kept", 32'(ib.dout_valid), 32'd1);
      drain_b("mid_drain");

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
